intmul_pipe: RTL and testbench
==============================

INTMUL_PIPE -- requirements
Module: intmul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 255: operand width in bits, range 16..512.
REQ-002 SHALL have parameter A_TILE, default 17: A-operand tile width in bits, range 1..27.
REQ-003 SHALL have parameter B_TILE, default 24: B-operand tile width in bits, range 1..27.
REQ-004 SHALL have parameter ADD_STAGES, default 2: number of register stages in the adder tree, range 1..4.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: operands a and b are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: the block accepts the operands this cycle.
REQ-009 SHALL have port a, input, WIDTH: multiplicand, unsigned.
REQ-010 SHALL have port b, input, WIDTH: multiplier, unsigned.
REQ-011 SHALL have port out_valid, output, 1: d holds a valid product.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts d this cycle.
REQ-013 SHALL have port d, output, 2*WIDTH: registered product a*b.

Function
REQ-014 SHALL split a into ceil(WIDTH/A_TILE) tiles and b into ceil(WIDTH/B_TILE) tiles; the top tile of each holds only the remaining bits, zero-extended.
REQ-015 SHALL register every tile product at A_TILE+B_TILE bits in pipeline stage 1.
REQ-016 SHALL sum the shifted partial products over ADD_STAGES register stages; the final stage drives d, so latency LAT = 1+ADD_STAGES cycles.
REQ-017 SHALL produce d exactly equal to a*b modulo 2^(2*WIDTH), with no truncation; the full product always fits in 2*WIDTH bits.
REQ-018 SHALL accept a transfer when in_valid && in_ready, and SHALL deliver a transfer when out_valid && out_ready.
REQ-019 SHALL stall the whole pipeline (global enable low) when out_valid && !out_ready; while stalled, d, out_valid and all internal stages SHALL hold their values.
REQ-020 SHALL drive in_ready = !(out_valid && !out_ready), as combinational logic with no other dependency.
REQ-021 SHALL track validity with a LAT-bit shift register advanced only on enable; bubbles SHALL propagate as invalid slots.
REQ-022 SHALL sustain one result per cycle when out_ready is held high, and SHALL preserve result order.
REQ-023 SHALL let d and internal data registers take any value when their validity bit is 0; only d gated by out_valid is meaningful.

Reset
REQ-024 SHALL clear out_valid and all validity bits on rst, and SHALL set d to 0.
REQ-025 SHALL discard in-flight operations when rst is asserted mid-operation; no output for them SHALL appear after reset.
REQ-026 SHALL drive in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-027 With macro INTMUL_PIPE_TAG_EN defined, SHALL add parameter TAG_W (default 8) and ports in_tag (input, TAG_W) and out_tag (output, TAG_W); the tag SHALL travel with its operands, appear aligned with out_valid, stall with the pipeline, and reset to 0.
REQ-028 Without INTMUL_PIPE_TAG_EN, SHALL have neither the tag ports nor the tag registers.

Structure
REQ-029 SHALL take from shared package intmul_pkg the default constants (WIDTH, A_TILE, B_TILE, ADD_STAGES) and a ceil-division function for tile counts.
REQ-030 SHALL build each tile product with sub-module intmul_tile (registered A_TILE x B_TILE unsigned multiplier with enable, DSP-mapped); the adder tree stays in intmul_pipe.

Verification
REQ-031 SHALL check: defaults, a=0, b=2^255-1 -> d=0 with out_valid after 3 cycles.
REQ-032 SHALL check: a=b=2^255-1 -> d = 2^510 - 2^256 + 1.
REQ-033 SHALL check: 1000 random back-to-back pairs with out_ready=1 -> one correct result per cycle, in order, in_ready constantly 1.
REQ-034 SHALL check: out_ready=0 for 5 cycles with the pipeline full -> d and out_valid held, in_ready=0, no loss or duplication after release.
REQ-035 SHALL check: rst pulsed with 2 operations in flight -> out_valid=0 and d=0 next cycle, with no stale results afterwards.
REQ-036 SHALL check: WIDTH=64, A_TILE=17, B_TILE=24, ADD_STAGES=1 with random operands -> exact product at latency 2; with INTMUL_PIPE_TAG_EN, out_tag matches in_tag per result.

Source files
------------

// File: rtl/intmul_pkg.sv
// Shared defaults and elaboration-time helpers for the tiled integer multiplier.
package intmul_pkg;

  localparam int unsigned DEF_WIDTH      = 255;
  localparam int unsigned DEF_A_TILE     = 17;
  localparam int unsigned DEF_B_TILE     = 24;
  localparam int unsigned DEF_ADD_STAGES = 2;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned m);
    return (n + m - 1) / m;
  endfunction

  function automatic int unsigned ipow(input int unsigned base, input int unsigned exp);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < exp; i++) r = r * base;
    return r;
  endfunction

  // Smallest per-stage fan-in that reduces n terms to one within the given stage count.
  function automatic int unsigned tree_fanin(input int unsigned n, input int unsigned stages);
    int unsigned f;
    f = 1;
    while (ipow(f, stages) < n) f++;
    return f;
  endfunction

  function automatic int unsigned lvl_count(input int unsigned n, input int unsigned f,
                                            input int unsigned k);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < k; i++) c = ceil_div(c, f);
    return c;
  endfunction

endpackage

// File: rtl/intmul_tile.sv
// Registered unsigned A_W x B_W tile multiplier with clock enable (DSP-friendly, no reset).
module intmul_tile #(
  parameter int unsigned A_W = 17,
  parameter int unsigned B_W = 24
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic [A_W+B_W-1:0]   p
);

  logic [A_W+B_W-1:0] p_d, p_q;

  always_comb begin
    p_d = p_q;
    if (en) p_d = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
  end

  always_ff @(posedge clk) p_q <= p_d;

  assign p = p_q;

endmodule

// File: rtl/intmul_pipe.sv
// Pipelined tiled unsigned multiplier, latency 1+ADD_STAGES, global stall on backpressure.
// Optional tag side-channel enabled by macro INTMUL_PIPE_TAG_EN.
module intmul_pipe
  import intmul_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned A_TILE     = DEF_A_TILE,
  parameter int unsigned B_TILE     = DEF_B_TILE,
  parameter int unsigned ADD_STAGES = DEF_ADD_STAGES
`ifdef INTMUL_PIPE_TAG_EN
  , parameter int unsigned TAG_W    = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   d
`ifdef INTMUL_PIPE_TAG_EN
  , input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]     out_tag
`endif
);

  localparam int unsigned LAT = 1 + ADD_STAGES;
  localparam int unsigned NA  = ceil_div(WIDTH, A_TILE);
  localparam int unsigned NB  = ceil_div(WIDTH, B_TILE);
  localparam int unsigned NP  = NA * NB;
  localparam int unsigned PW  = A_TILE + B_TILE;
  localparam int unsigned DW  = 2 * WIDTH;
  localparam int unsigned TW  = (PW < DW) ? PW : DW;
  localparam int unsigned FAN = tree_fanin(NP, ADD_STAGES);

  logic                 en;
  logic [LAT-1:0]       vld_d, vld_q;
  logic [NA*A_TILE-1:0] a_ext;
  logic [NB*B_TILE-1:0] b_ext;
  logic [PW-1:0]        prod [NP];
  logic [DW-1:0]        term [NP];

  always_comb begin
    en        = !(vld_q[LAT-1] && !out_ready);
    in_ready  = en;
    out_valid = vld_q[LAT-1];
  end

  always_comb begin
    vld_d = vld_q;
    if (en) vld_d = {vld_q[LAT-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_comb begin
    a_ext            = '0;
    a_ext[WIDTH-1:0] = a;
    b_ext            = '0;
    b_ext[WIDTH-1:0] = b;
  end

  for (genvar i = 0; i < NA; i++) begin : g_ta
    for (genvar j = 0; j < NB; j++) begin : g_tb
      intmul_tile #(.A_W(A_TILE), .B_W(B_TILE)) u_tile (
        .clk (clk),
        .en  (en),
        .a   (a_ext[i*A_TILE +: A_TILE]),
        .b   (b_ext[j*B_TILE +: B_TILE]),
        .p   (prod[i*NB + j])
      );
    end
  end

  // Tile products never exceed the full product, so clipping to DW bits is lossless.
  always_comb begin
    for (int unsigned k = 0; k < NP; k++) begin
      term[k]         = '0;
      term[k][TW-1:0] = prod[k][TW-1:0];
      term[k]         = term[k] << ((k / NB) * A_TILE + (k % NB) * B_TILE);
    end
  end

  for (genvar s = 0; s < ADD_STAGES; s++) begin : g_lvl
    localparam int unsigned N_IN  = lvl_count(NP, FAN, s);
    localparam int unsigned N_OUT = lvl_count(NP, FAN, s + 1);

    logic [DW-1:0] src   [N_IN];
    logic [DW-1:0] acc_d [N_OUT];
    logic [DW-1:0] acc_q [N_OUT];

    if (s == 0) begin : g_src
      always_comb for (int unsigned k = 0; k < N_IN; k++) src[k] = term[k];
    end else begin : g_src
      always_comb for (int unsigned k = 0; k < N_IN; k++) src[k] = g_lvl[s-1].acc_q[k];
    end

    always_comb begin
      for (int unsigned g = 0; g < N_OUT; g++) begin
        acc_d[g] = '0;
        for (int unsigned k = g * FAN; k < N_IN && k < (g + 1) * FAN; k++)
          acc_d[g] = acc_d[g] + src[k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned g = 0; g < N_OUT; g++) acc_q[g] <= '0;
      end else if (en) begin
        acc_q <= acc_d;
      end
    end
  end

  assign d = g_lvl[ADD_STAGES-1].acc_q[0];

`ifdef INTMUL_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_d [LAT];
  logic [TAG_W-1:0] tag_q [LAT];

  always_comb begin
    tag_d = tag_q;
    if (en) begin
      tag_d[0] = in_tag;
      for (int unsigned k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign out_tag = tag_q[LAT-1];
`endif

endmodule

// File: tb/tb_intmul_pipe.sv
// Directed and streamed checks of intmul_pipe at default size and at WIDTH=64/ADD_STAGES=1.
module tb_intmul_pipe;

  localparam int unsigned W = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             iv, ir, ov, ordy;
  logic [W-1:0]     a, b;
  logic [2*W-1:0]   d;
  logic             iv64, ir64, ov64, ordy64;
  logic [63:0]      a64, b64;
  logic [127:0]     d64;
`ifdef INTMUL_PIPE_TAG_EN
  logic [7:0]       tin, tout, tin64, tout64;
  logic [7:0]       qt[$];
  logic [7:0]       qt64[$];
`endif

  int unsigned      nchk = 0;
  int unsigned      nbad = 0;
  int unsigned      ndel = 0;
  int unsigned      ndel64 = 0;
  logic [511:0]     q[$];
  logic [127:0]     q64[$];

  intmul_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy), .d(d)
`ifdef INTMUL_PIPE_TAG_EN
    , .in_tag(tin), .out_tag(tout)
`endif
  );

  intmul_pipe #(.WIDTH(64), .A_TILE(17), .B_TILE(24), .ADD_STAGES(1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(ordy64), .d(d64)
`ifdef INTMUL_PIPE_TAG_EN
    , .in_tag(tin64), .out_tag(tout64)
`endif
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [509:0] mul255(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] xx, yy;
    xx = 510'(x);
    yy = 510'(y);
    return xx * yy;
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r[254:0];
  endfunction

  // One clock: score deliveries and acceptances seen before the edge, then advance.
  task automatic step();
    #1;
    if (ov && ordy) begin
      ndel++;
      if (q.size() == 0) check_eq("spurious", 512'(ov), 512'(0));
      else               check_eq("d", 512'(d), q.pop_front());
`ifdef INTMUL_PIPE_TAG_EN
      if (qt.size() != 0) check_eq("tag", 512'(tout), 512'(qt.pop_front()));
`endif
    end
    if (ov64 && ordy64) begin
      ndel64++;
      if (q64.size() == 0) check_eq("spurious64", 512'(ov64), 512'(0));
      else                 check_eq("d64", 512'(d64), 512'(q64.pop_front()));
`ifdef INTMUL_PIPE_TAG_EN
      if (qt64.size() != 0) check_eq("tag64", 512'(tout64), 512'(qt64.pop_front()));
`endif
    end
    if (iv && ir) begin
      q.push_back(512'(mul255(a, b)));
`ifdef INTMUL_PIPE_TAG_EN
      qt.push_back(tin);
`endif
    end
    if (iv64 && ir64) begin
      q64.push_back(128'(a64) * 128'(b64));
`ifdef INTMUL_PIPE_TAG_EN
      qt64.push_back(tin64);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  logic [254:0] ta [4];
  logic [254:0] tb [4];
  logic [509:0] te [4];
  int unsigned  n0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0;
    iv64 = 1'b0; ordy64 = 1'b1; a64 = '0; b64 = '0;
`ifdef INTMUL_PIPE_TAG_EN
    tin = '0; tin64 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ov", 512'(ov), 512'(0));
    check_eq("rst_d", 512'(d), 512'(0));
    check_eq("rst_ov64", 512'(ov64), 512'(0));
`ifdef INTMUL_PIPE_TAG_EN
    check_eq("rst_tag", 512'(tout), 512'(0));
`endif
    rst = 1'b0;
    check_eq("ir_after_rst", 512'(ir), 512'(1));

    // a=0, b=2^255-1: zero product, valid exactly three edges later
    a = '0; b = '1; iv = 1'b1;
    step();
    iv = 1'b0;
    check_eq("lat_e1", 512'(ov), 512'(0));
    step();
    check_eq("lat_e2", 512'(ov), 512'(0));
    step();
    check_eq("lat_e3", 512'(ov), 512'(1));
    check_eq("zero_d", 512'(d), 512'(0));
    step();

    // (2^255-1)^2 = 2^510 - 2^256 + 1
    a = '1; b = '1; iv = 1'b1;
    step();
    iv = 1'b0;
    step();
    step();
    check_eq("max_ov", 512'(ov), 512'(1));
    check_eq("max_d", 512'(d), 512'({{254{1'b1}}, {255{1'b0}}, 1'b1}));
    step();

    // 1000 back-to-back random pairs
    n0 = ndel;
    for (int i = 0; i < 1000; i++) begin
      a = rnd255(); b = rnd255(); iv = 1'b1;
`ifdef INTMUL_PIPE_TAG_EN
      tin = 8'(i);
`endif
      check_eq("stream_ir", 512'(ir), 512'(1));
      if (i >= 3) check_eq("stream_tput", 512'(ov), 512'(1));
      step();
    end
    iv = 1'b0;
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    check_eq("stream_drain", 512'(q.size()), 512'(0));
    check_eq("stream_count", 512'(ndel - n0), 512'(1000));

    // stall with a full pipeline
    ta[0] = 255'd3;    tb[0] = 255'd5;    te[0] = 510'd15;
    ta[1] = 255'd7;    tb[1] = 255'd11;   te[1] = 510'd77;
    ta[2] = 255'd1000; tb[2] = 255'd1000; te[2] = 510'd1000000;
    ta[3] = '0;        tb[3] = 255'd4;    te[3] = '0;
    ta[3][254] = 1'b1;
    te[3][256] = 1'b1;
    n0 = ndel;
    for (int k = 0; k < 3; k++) begin
      a = ta[k]; b = tb[k]; iv = 1'b1;
      step();
    end
    check_eq("fill_d", 512'(d), 512'(te[0]));
    a = ta[3]; b = tb[3]; ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("stall_ov", 512'(ov), 512'(1));
      check_eq("stall_d", 512'(d), 512'(te[0]));
      check_eq("stall_ir", 512'(ir), 512'(0));
    end
    ordy = 1'b1;
    step();
    iv = 1'b0;
    check_eq("rel_d1", 512'(d), 512'(te[1]));
    step();
    check_eq("rel_d2", 512'(d), 512'(te[2]));
    step();
    check_eq("rel_d3", 512'(d), 512'(te[3]));
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    check_eq("stall_drain", 512'(q.size()), 512'(0));
    check_eq("stall_count", 512'(ndel - n0), 512'(4));

    // reset pulse with two operations in flight
    for (int k = 0; k < 2; k++) begin
      a = rnd255(); b = rnd255(); iv = 1'b1;
      step();
    end
    iv = 1'b0; rst = 1'b1;
    step();
    check_eq("mid_rst_ov", 512'(ov), 512'(0));
    check_eq("mid_rst_d", 512'(d), 512'(0));
    q.delete();
`ifdef INTMUL_PIPE_TAG_EN
    qt.delete();
`endif
    rst = 1'b0;
    check_eq("mid_rst_ir", 512'(ir), 512'(1));
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("stale", 512'(ov), 512'(0));
    end

    // WIDTH=64 instance: latency 2
    a64 = '1; b64 = '1; iv64 = 1'b1;
`ifdef INTMUL_PIPE_TAG_EN
    tin64 = 8'hA5;
`endif
    step();
    iv64 = 1'b0;
    check_eq("w64_e1", 512'(ov64), 512'(0));
    step();
    check_eq("w64_e2", 512'(ov64), 512'(1));
    check_eq("w64_max", 512'(d64), 512'(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001));
`ifdef INTMUL_PIPE_TAG_EN
    check_eq("w64_tag", 512'(tout64), 512'(8'hA5));
`endif
    step();
    n0 = ndel64;
    for (int i = 0; i < 200; i++) begin
      a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()}; iv64 = 1'b1;
`ifdef INTMUL_PIPE_TAG_EN
      tin64 = 8'(i * 3);
`endif
      step();
    end
    iv64 = 1'b0;
    for (int k = 0; k < 10 && q64.size() != 0; k++) step();
    check_eq("w64_drain", 512'(q64.size()), 512'(0));
    check_eq("w64_count", 512'(ndel64 - n0), 512'(200));

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
